// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - eight-digit seven-segment scan controller with blanking guard band
module display_scan_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int FRAME_HZ     = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] digit_mask,
  output logic [2:0] sel,
  output logic [7:0] an_n,
  output logic       frame_done
);

  localparam int SLOT_CYCLES  = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int DRIVE_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam int CW           = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
  localparam logic [7:0]    KEEP_MASK  = 8'((1 << NUM_DIGITS) - 1);

  // A slot must leave room for at least one drive cycle after the guard band.
  if (SLOT_CYCLES <= BLANK_CYCLES) begin : g_bad_slot
    $error("display_scan_ctrl: SLOT_CYCLES must exceed BLANK_CYCLES");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("display_scan_ctrl: BLANK_CYCLES must be at least 1");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("display_scan_ctrl: NUM_DIGITS must be within 2..8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    sel_n;
  logic [7:0]    an_n_n;
  logic          fd_n;

  logic [7:0]    eff_mask;
  logic [2:0]    low_idx;
  logic [2:0]    nxt_idx;
  logic          nxt_found;
  logic          wrap;

  // Digits beyond the physical count never take part in the scan.
  assign eff_mask = digit_mask & KEEP_MASK;

  // Lowest enabled digit, used when a scan starts from IDLE.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (eff_mask[3'(i)]) begin
        low_idx = 3'(i);
      end
    end
  end

  // Nearest enabled digit strictly after sel, searching cyclically; a single
  // enabled digit finds itself after a full lap.
  always_comb begin
    int idx;
    idx       = 0;
    nxt_idx   = sel;
    nxt_found = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      idx = (int'(sel) + k) % NUM_DIGITS;
      if (!nxt_found && eff_mask[idx[2:0]]) begin
        nxt_idx   = idx[2:0];
        nxt_found = 1'b1;
      end
    end
  end

  assign wrap = (nxt_idx <= sel);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    fd_n    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eff_mask) begin
            state_n = BLANK;
            cnt_n   = '0;
            sel_n   = low_idx;
            fd_n    = 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            cnt_n = '0;
            if (|eff_mask) begin
              state_n = BLANK;
              sel_n   = nxt_idx;
              fd_n    = wrap;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    // The anode follows the state being entered, so it is never low while sel moves.
    an_n_n = (state_n == DRIVE) ? ~(8'd1 << sel_n) : 8'hFF;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      an_n       <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      an_n       <= an_n_n;
      frame_done <= fd_n;
    end
  end

endmodule
